intr_sched: RTL and testbench
=============================

INTR_SCHED -- requirements
Module: intr_sched

Interface
REQ-001 SHALL have parameter NUM_INTRS, default 7, number of interrupt sources (2..32).
REQ-002 SHALL have parameter EDGE_MASK, default all ones, per-source trigger mode (1 = rising edge, 0 = level-high).
REQ-003 SHALL have port coreclk  input  1  single clock; all logic is synchronous to it.
REQ-004 SHALL have port corersts  input  1  synchronous, active-high reset.
REQ-005 SHALL have port intrs  input  NUM_INTRS  raw interrupt lines (bit 0 = mm2s, bit 1 = s2mm, then uart0..3 and ethernet).
REQ-006 SHALL have port en_we  input  1  enable-register write strobe.
REQ-007 SHALL have port en_wdata  input  NUM_INTRS  new enable mask.
REQ-008 SHALL have port en_q  output  NUM_INTRS  current enable mask.
REQ-009 SHALL have port irq  output  1  interrupt request to the core.
REQ-010 SHALL have port claim_valid  input  1  one-cycle claim request.
REQ-011 SHALL have port claim_ack  output  1  claim response strobe.
REQ-012 SHALL have port claim_hit  output  1  claim returned a source.
REQ-013 SHALL have port claim_id  output  $clog2(NUM_INTRS)  granted source index.
REQ-014 SHALL have port complete_valid  input  1  one-cycle service-complete strobe.
REQ-015 SHALL have port complete_id  input  $clog2(NUM_INTRS)  completed source index.

Function
REQ-016 Each source SHALL run a gateway FSM with states IDLE, PENDING, ACTIVE and ACTIVE_RETRIG.
REQ-017 Transition IDLE->PENDING SHALL occur on the edge after the trigger is seen: an edge source needs intrs rising (0 in the previous sampled cycle, 1 now); a level source needs intrs=1.
REQ-018 Source latency SHALL be 1 cycle, from intrs sampled at edge N to pending and irq visible after edge N.
REQ-019 irq SHALL equal OR(pending & en_q), decoded directly from registers.
REQ-020 Disabled sources SHALL still latch pending but SHALL NOT drive irq or be granted.
REQ-021 Round-robin arbitration on claim_valid:
- Search starts at last-granted index + 1 and wraps modulo NUM_INTRS.
- The first source that is both pending and enabled is granted.
- The granted source moves PENDING->ACTIVE.
- The last-granted pointer updates to the granted index.
REQ-022 claim_ack SHALL assert exactly one cycle after claim_valid.
- On a grant: claim_hit=1 and claim_id holds the granted index.
- With no eligible source: claim_hit=0, claim_id=0, and the pointer is unchanged.
REQ-023 claim_id and claim_hit SHALL hold their values until the next claim_ack.
REQ-024 On complete_valid with an in-range complete_id, the named source SHALL move ACTIVE->IDLE or ACTIVE_RETRIG->PENDING.
- complete_valid is ignored for an out-of-range id or a source in IDLE or PENDING.
REQ-025 An edge source SHALL move ACTIVE->ACTIVE_RETRIG on a new rising edge.
- Further edges while PENDING or ACTIVE_RETRIG are merged, not counted.
REQ-026 A level source SHALL ignore intrs while ACTIVE, and SHALL re-enter PENDING from IDLE if the line is still high after completion.
REQ-027 If claim_valid and complete_valid occur in the same cycle, both SHALL take effect.
- A complete_id equal to the source being granted is ignored, because that source is PENDING.
REQ-028 A retrigger edge arriving in the same cycle as its completion SHALL produce PENDING.
REQ-029 en_we SHALL update en_q on the next edge; the new mask affects irq and arbitration from the following cycle.
REQ-030 en_we in the same cycle as claim_valid SHALL arbitrate with the old mask.

Reset
REQ-031 On corersts, all of the following SHALL hold on the next edge:
- all gateways IDLE;
- en_q = 0, irq = 0;
- claim_ack = 0, claim_hit = 0, claim_id = 0;
- last-granted pointer = NUM_INTRS-1, so the first search starts at 0;
- edge-history register = 0.
REQ-032 Reset asserted mid-claim SHALL suppress the pending claim_ack.
REQ-033 Inputs SHALL be ignored in any cycle where corersts=1.

Configuration
REQ-034 With INTR_SYNC_EN defined, intrs SHALL pass through a 2-flop synchronizer per bit, giving a source latency of 3 cycles; without it, intrs are used directly with 1-cycle latency.
REQ-035 Synchronizer flops SHALL reset to 0.

Structure
REQ-036 Package intr_pkg SHALL hold the gateway state enum, the default NUM_INTRS, and the source index constants (MM2S=0, S2MM=1, UART0..3=2..5, ETH=6).
REQ-037 Sub-module intr_gateway SHALL implement one source FSM and SHALL be instantiated NUM_INTRS times.
- Its outputs are pending/active; its inputs are trig, grant and complete.

Verification
REQ-038 Edge source: intrs[3] pulses one cycle with en_q=all ones -> irq=1 on the next cycle; claim -> ack with hit=1, id=3; irq=0 afterwards.
REQ-039 Round-robin: sources 1, 4 and 6 pending; three back-to-back claims -> ids 1, 4, 6; a fourth claim -> hit=0, id=0.
REQ-040 Retrigger: claim source 0, pulse intrs[0] again, complete 0 -> source 0 PENDING and irq=1; claim -> id 0.
REQ-041 Level source (EDGE_MASK bit 2 = 0): intrs[2] held high, claim, then complete -> PENDING again the next cycle; drop intrs[2] before completing -> IDLE and irq=0.
REQ-042 Masking: source 5 pending with en_q=0 -> irq=0 and claim returns hit=0; write en_wdata=0x20 -> irq=1 and claim returns id 5.
REQ-043 Reset while sources 1 and 2 are ACTIVE and a claim is in flight -> no claim_ack, irq=0, en_q=0; the first post-reset grant searches from 0.

Source files
------------

// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the interrupt scheduler
package intr_pkg;

    typedef enum logic [1:0] {
        GW_IDLE          = 2'd0,
        GW_PENDING       = 2'd1,
        GW_ACTIVE        = 2'd2,
        GW_ACTIVE_RETRIG = 2'd3
    } gw_state_e;

    localparam int DEFAULT_NUM_INTRS = 7;

    localparam int MM2S  = 0;
    localparam int S2MM  = 1;
    localparam int UART0 = 2;
    localparam int UART1 = 3;
    localparam int UART2 = 4;
    localparam int UART3 = 5;
    localparam int ETH   = 6;

endpackage

// File: rtl/intr_gateway.sv
// rtl/intr_gateway.sv - per-source gateway FSM (idle/pending/active/retrigger)
module intr_gateway
    import intr_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    input  logic grant_i,
    input  logic complete_i,
    output logic pending_o,
    output logic active_o
);

    gw_state_e state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= GW_IDLE;
        end else begin
            case (state_q)
                GW_IDLE: begin
                    if (trig_i) state_q <= GW_PENDING;
                end
                GW_PENDING: begin
                    if (grant_i) state_q <= GW_ACTIVE;
                end
                // Level sources ignore the line while being serviced; edges are remembered.
                GW_ACTIVE: begin
                    if (complete_i)
                        state_q <= (EDGE && trig_i) ? GW_PENDING : GW_IDLE;
                    else if (EDGE && trig_i)
                        state_q <= GW_ACTIVE_RETRIG;
                end
                GW_ACTIVE_RETRIG: begin
                    if (complete_i) state_q <= GW_PENDING;
                end
                default: state_q <= GW_IDLE;
            endcase
        end
    end

    assign pending_o = (state_q == GW_PENDING);
    assign active_o  = (state_q == GW_ACTIVE) || (state_q == GW_ACTIVE_RETRIG);

endmodule

// File: rtl/intr_sched.sv
// rtl/intr_sched.sv - round-robin interrupt scheduler; INTR_SYNC_EN adds 2-flop input synchronizers
module intr_sched
    import intr_pkg::*;
#(
    parameter int                   NUM_INTRS = DEFAULT_NUM_INTRS,
    parameter logic [NUM_INTRS-1:0] EDGE_MASK = '1
) (
    input  logic                         coreclk,
    input  logic                         corersts,
    input  logic [NUM_INTRS-1:0]         intrs,
    input  logic                         en_we,
    input  logic [NUM_INTRS-1:0]         en_wdata,
    output logic [NUM_INTRS-1:0]         en_q,
    output logic                         irq,
    input  logic                         claim_valid,
    output logic                         claim_ack,
    output logic                         claim_hit,
    output logic [$clog2(NUM_INTRS)-1:0] claim_id,
    input  logic                         complete_valid,
    input  logic [$clog2(NUM_INTRS)-1:0] complete_id
);

    localparam int IDW = $clog2(NUM_INTRS);

    logic [NUM_INTRS-1:0] intrs_s;
    logic [NUM_INTRS-1:0] prev_q;
    logic [NUM_INTRS-1:0] en_mask_q;
    logic [NUM_INTRS-1:0] trig;
    logic [NUM_INTRS-1:0] pending;
    logic [NUM_INTRS-1:0] active;
    logic [NUM_INTRS-1:0] eligible;
    logic [NUM_INTRS-1:0] grant_vec;
    logic [NUM_INTRS-1:0] comp_vec;
    logic                 ack_q;
    logic                 hit_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       last_q;
    logic                 hi_found;
    logic                 lo_found;
    logic [IDW-1:0]       hi_idx;
    logic [IDW-1:0]       lo_idx;
    logic                 found;
    logic [IDW-1:0]       win;
    logic                 comp_in_range;

`ifdef INTR_SYNC_EN
    logic [NUM_INTRS-1:0] sync1_q;
    logic [NUM_INTRS-1:0] sync2_q;

    always_ff @(posedge coreclk) begin
        if (corersts) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= intrs;
            sync2_q <= sync1_q;
        end
    end

    assign intrs_s = sync2_q;
`else
    assign intrs_s = intrs;
`endif

    assign trig     = intrs_s & (~prev_q | ~EDGE_MASK);
    assign eligible = pending & en_mask_q;
    assign irq      = |eligible;

    // Two-window search: lowest eligible index above the last grant, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_INTRS - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                if (j > int'(last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(j);
                end
            end
        end
        found = hi_found | lo_found;
        win   = hi_found ? hi_idx : lo_idx;
    end

    assign comp_in_range = complete_valid && (int'(complete_id) < NUM_INTRS);

    for (genvar g = 0; g < NUM_INTRS; g++) begin : g_gw
        assign grant_vec[g] = claim_valid && found && (win == IDW'(g));
        assign comp_vec[g]  = comp_in_range && (complete_id == IDW'(g)) && active[g];

        intr_gateway #(
            .EDGE(EDGE_MASK[g])
        ) u_gw (
            .clk_i     (coreclk),
            .rst_i     (corersts),
            .trig_i    (trig[g]),
            .grant_i   (grant_vec[g]),
            .complete_i(comp_vec[g]),
            .pending_o (pending[g]),
            .active_o  (active[g])
        );
    end

    always_ff @(posedge coreclk) begin
        if (corersts) begin
            en_mask_q <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            hit_q     <= 1'b0;
            id_q      <= '0;
            last_q    <= IDW'(NUM_INTRS - 1);
        end else begin
            if (en_we) en_mask_q <= en_wdata;
            prev_q <= intrs_s;
            ack_q  <= claim_valid;
            if (claim_valid) begin
                hit_q <= found;
                id_q  <= found ? win : '0;
                if (found) last_q <= win;
            end
        end
    end

    assign en_q      = en_mask_q;
    assign claim_ack = ack_q;
    assign claim_hit = hit_q;
    assign claim_id  = id_q;

endmodule

// File: tb/tb_intr_sched.sv
// tb/tb_intr_sched.sv - directed self-checking bench for intr_sched (source 2 level-triggered)
module tb_intr_sched;

    logic       coreclk = 1'b0;
    logic       corersts;
    logic [6:0] intrs;
    logic       en_we;
    logic [6:0] en_wdata;
    logic [6:0] en_q;
    logic       irq;
    logic       claim_valid;
    logic       claim_ack;
    logic       claim_hit;
    logic [2:0] claim_id;
    logic       complete_valid;
    logic [2:0] complete_id;

    int checks   = 0;
    int failures = 0;

    intr_sched #(
        .NUM_INTRS(7),
        .EDGE_MASK(7'b1111011)
    ) dut (
        .coreclk       (coreclk),
        .corersts      (corersts),
        .intrs         (intrs),
        .en_we         (en_we),
        .en_wdata      (en_wdata),
        .en_q          (en_q),
        .irq           (irq),
        .claim_valid   (claim_valid),
        .claim_ack     (claim_ack),
        .claim_hit     (claim_hit),
        .claim_id      (claim_id),
        .complete_valid(complete_valid),
        .complete_id   (complete_id)
    );

    always #5 coreclk = ~coreclk;

    task automatic tick();
        @(posedge coreclk);
        #1;
    endtask

    task automatic do_reset();
        intrs = '0; en_we = 0; en_wdata = '0; claim_valid = 0;
        complete_valid = 0; complete_id = '0;
        corersts = 1;
        tick(); tick();
        corersts = 0;
    endtask

    task automatic write_en(input logic [6:0] m);
        en_we = 1; en_wdata = m;
        tick();
        en_we = 0;
    endtask

    task automatic pulse(input logic [6:0] m);
        intrs = m;
        tick();
        intrs = '0;
    endtask

    task automatic claim_once();
        claim_valid = 1;
        tick();
        claim_valid = 0;
    endtask

    task automatic complete(input logic [2:0] id);
        complete_valid = 1; complete_id = id;
        tick();
        complete_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (en_q !== 7'h00) begin failures++; $display("FAIL reset_en_q: got %h expected 00", en_q); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if ({claim_ack, claim_hit, claim_id} !== 5'b0) begin failures++; $display("FAIL reset_claim: got ack=%b hit=%b id=%0d expected 0/0/0", claim_ack, claim_hit, claim_id); end
    endtask

    task automatic test_edge();
        write_en(7'h7f);
        checks++; if (en_q !== 7'h7f) begin failures++; $display("FAIL edge_en_q: got %h expected 7f", en_q); end
        pulse(7'h08);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq: got %b expected 1", irq); end
        claim_once();
        checks++; if ({claim_ack, claim_hit, claim_id} !== {1'b1, 1'b1, 3'd3}) begin failures++; $display("FAIL edge_claim: got ack=%b hit=%b id=%0d expected 1/1/3", claim_ack, claim_hit, claim_id); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_after: got %b expected 0", irq); end
        tick();
        checks++; if ({claim_ack, claim_hit, claim_id} !== {1'b0, 1'b1, 3'd3}) begin failures++; $display("FAIL edge_hold: got ack=%b hit=%b id=%0d expected 0/1/3", claim_ack, claim_hit, claim_id); end
        complete(3'd3);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_done_irq: got %b expected 0", irq); end
    endtask

    task automatic test_round_robin();
        do_reset();
        write_en(7'h7f);
        pulse(7'h52);
        claim_valid = 1;
        tick();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd1}) begin failures++; $display("FAIL rr_first: got hit=%b id=%0d expected 1/1", claim_hit, claim_id); end
        complete_valid = 1; complete_id = 3'd1;
        tick();
        complete_valid = 0;
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd4}) begin failures++; $display("FAIL rr_second: got hit=%b id=%0d expected 1/4", claim_hit, claim_id); end
        tick();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd6}) begin failures++; $display("FAIL rr_third: got hit=%b id=%0d expected 1/6", claim_hit, claim_id); end
        tick();
        claim_valid = 0;
        checks++; if ({claim_ack, claim_hit, claim_id} !== {1'b1, 1'b0, 3'd0}) begin failures++; $display("FAIL rr_empty: got ack=%b hit=%b id=%0d expected 1/0/0", claim_ack, claim_hit, claim_id); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rr_irq: got %b expected 0", irq); end
        complete(3'd4);
        complete(3'd6);
        pulse(7'h02);
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd1}) begin failures++; $display("FAIL rr_concurrent_complete: got hit=%b id=%0d expected 1/1", claim_hit, claim_id); end
        complete(3'd1);
    endtask

    task automatic test_retrigger();
        do_reset();
        write_en(7'h7f);
        pulse(7'h01);
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd0}) begin failures++; $display("FAIL retrig_claim: got hit=%b id=%0d expected 1/0", claim_hit, claim_id); end
        pulse(7'h01);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL retrig_active_irq: got %b expected 0", irq); end
        complete(3'd0);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL retrig_pending_irq: got %b expected 1", irq); end
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd0}) begin failures++; $display("FAIL retrig_reclaim: got hit=%b id=%0d expected 1/0", claim_hit, claim_id); end
        intrs = 7'h01; complete_valid = 1; complete_id = 3'd0;
        tick();
        intrs = '0; complete_valid = 0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL retrig_same_cycle: got %b expected 1", irq); end
        claim_once();
        complete(3'd0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL retrig_done: got %b expected 0", irq); end
    endtask

    task automatic test_level();
        do_reset();
        write_en(7'h7f);
        intrs = 7'h04;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq: got %b expected 1", irq); end
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd2}) begin failures++; $display("FAIL level_claim: got hit=%b id=%0d expected 1/2", claim_hit, claim_id); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_active_irq: got %b expected 0", irq); end
        complete(3'd2);
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_repend: got %b expected 1", irq); end
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd2}) begin failures++; $display("FAIL level_reclaim: got hit=%b id=%0d expected 1/2", claim_hit, claim_id); end
        intrs = '0;
        tick();
        complete(3'd2);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_dropped: got %b expected 0", irq); end
    endtask

    task automatic test_mask();
        do_reset();
        pulse(7'h20);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq: got %b expected 0", irq); end
        claim_valid = 1; en_we = 1; en_wdata = 7'h20;
        tick();
        claim_valid = 0; en_we = 0;
        checks++; if ({claim_ack, claim_hit, claim_id} !== {1'b1, 1'b0, 3'd0}) begin failures++; $display("FAIL mask_old_mask_claim: got ack=%b hit=%b id=%0d expected 1/0/0", claim_ack, claim_hit, claim_id); end
        checks++; if (en_q !== 7'h20) begin failures++; $display("FAIL mask_en_q: got %h expected 20", en_q); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_irq_enabled: got %b expected 1", irq); end
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd5}) begin failures++; $display("FAIL mask_claim: got hit=%b id=%0d expected 1/5", claim_hit, claim_id); end
        pulse(7'h20);
        complete(3'd7);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_bad_id: got %b expected 0", irq); end
        complete(3'd5);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_retrig_complete: got %b expected 1", irq); end
        claim_once();
        complete(3'd5);
    endtask

    task automatic test_reset_midclaim();
        do_reset();
        write_en(7'h7f);
        pulse(7'h06);
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd1}) begin failures++; $display("FAIL rst_pre_claim1: got hit=%b id=%0d expected 1/1", claim_hit, claim_id); end
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd2}) begin failures++; $display("FAIL rst_pre_claim2: got hit=%b id=%0d expected 1/2", claim_hit, claim_id); end
        pulse(7'h08);
        corersts = 1; claim_valid = 1; en_we = 1; en_wdata = 7'h7f;
        tick();
        corersts = 0; claim_valid = 0; en_we = 0;
        checks++; if (claim_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b expected 0", claim_ack); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b expected 0", irq); end
        checks++; if (en_q !== 7'h00) begin failures++; $display("FAIL rst_en_q: got %h expected 00", en_q); end
        tick();
        checks++; if (claim_ack !== 1'b0) begin failures++; $display("FAIL rst_ack_late: got %b expected 0", claim_ack); end
        write_en(7'h7f);
        pulse(7'h42);
        claim_once();
        checks++; if ({claim_hit, claim_id} !== {1'b1, 3'd1}) begin failures++; $display("FAIL rst_ptr: got hit=%b id=%0d expected 1/1", claim_hit, claim_id); end
    endtask

    initial begin
        corersts = 1; intrs = '0; en_we = 0; en_wdata = '0;
        claim_valid = 0; complete_valid = 0; complete_id = '0;
        test_reset();
        test_edge();
        test_round_robin();
        test_retrigger();
        test_level();
        test_mask();
        test_reset_midclaim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
